// File: rtl/inst_mem.sv
// Instruction memory: DEPTH x 16-bit words, boot image preloaded,
// one-cycle registered fetch. Define INSTMEM_LOAD_EN to add a write port.
module inst_mem #(
    parameter int unsigned DEPTH    = 256,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] pc,
`ifdef INSTMEM_LOAD_EN
    input  logic        load_en,
    input  logic [15:0] load_addr,
    input  logic [15:0] load_data,
`endif
    output logic [15:0] instruction,
    output logic        valid,
    output logic        addr_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [DEPTH-1:0][15:0] image_t;

    function automatic image_t boot_image();
        image_t img;
        img = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            case (i)
                0:       img[i] = 16'h1101;
                1:       img[i] = 16'h1202;
                2:       img[i] = 16'h2312;
                3:       img[i] = 16'h3412;
                4:       img[i] = 16'h4000;
                5:       img[i] = 16'hF000;
                default: img[i] = 16'h0000;
            endcase
        end
        return img;
    endfunction

    localparam image_t BOOT = boot_image();

    // No wrap-around: the full 16-bit address is compared against DEPTH.
    function automatic logic in_range(input logic [15:0] a);
        return {1'b0, a} < 17'(DEPTH);
    endfunction

    logic [AW-1:0] fetch_idx;
    logic          fetch_ok;
    logic [15:0]   rd_word;

    assign fetch_idx = pc[AW-1:0];
    assign fetch_ok  = in_range(pc);

`ifdef INSTMEM_LOAD_EN
    image_t        mem = BOOT;
    logic [AW-1:0] load_idx;
    logic          load_ok;

    assign load_idx = load_addr[AW-1:0];
    assign load_ok  = in_range(load_addr);
    assign rd_word  = mem[fetch_idx];

    // Loader write; the fetch samples the old word on the same edge.
    always_ff @(posedge clk) begin
        if (!reset && load_en && load_ok) begin
            mem[load_idx] <= load_data;
        end
    end
`else
    assign rd_word = BOOT[fetch_idx];
`endif

    // Registered fetch: reset clears outputs, idle cycles hold data and drop valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            instruction <= 16'h0000;
            valid       <= 1'b0;
            addr_err    <= 1'b0;
        end else if (enable) begin
            valid <= 1'b1;
            if (fetch_ok) begin
                instruction <= rd_word;
                addr_err    <= 1'b0;
            end else begin
                instruction <= NOP_WORD;
                addr_err    <= 1'b1;
            end
        end else begin
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inst_mem.sv
// Bench for inst_mem: directed vector table, load corner cases
// (when INSTMEM_LOAD_EN is defined) and randomized model comparison.
module tb_inst_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] pc;
    logic [15:0] instruction;
    logic        valid;
    logic        addr_err;
`ifdef INSTMEM_LOAD_EN
    logic        load_en;
    logic [15:0] load_addr;
    logic [15:0] load_data;
`endif

    inst_mem #(.DEPTH(256), .NOP_WORD(16'h0000)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .pc(pc),
`ifdef INSTMEM_LOAD_EN
        .load_en(load_en),
        .load_addr(load_addr),
        .load_data(load_data),
`endif
        .instruction(instruction),
        .valid(valid),
        .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [15:0] ref_mem [256];
    logic [15:0] m_instr = 16'h0000;
    logic        m_valid = 1'b0;
    logic        m_err   = 1'b0;

    typedef struct {
        logic        rst;
        logic        en;
        logic [15:0] pc;
        logic [15:0] instr;
        logic        v;
        logic        err;
    } vec_t;

    vec_t vt [17];

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Advance one rising edge, updating the model from the applied inputs.
    task automatic tick();
        logic ld;
        @(posedge clk);
        ld = 1'b0;
`ifdef INSTMEM_LOAD_EN
        ld = load_en;
`endif
        if (reset) begin
            m_instr = 16'h0000;
            m_valid = 1'b0;
            m_err   = 1'b0;
        end else if (enable) begin
            m_valid = 1'b1;
            if (pc < 16'd256) begin
                m_instr = ref_mem[pc];
                m_err   = 1'b0;
            end else begin
                m_instr = 16'h0000;
                m_err   = 1'b1;
            end
        end else begin
            m_valid = 1'b0;
        end
`ifdef INSTMEM_LOAD_EN
        if (!reset && ld && load_addr < 16'd256)
            ref_mem[load_addr] = load_data;
`endif
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_instr"}, instruction, m_instr);
        chk({tag, "_valid"}, 16'(valid), 16'(m_valid));
        chk({tag, "_err"}, 16'(addr_err), 16'(m_err));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
        ref_mem[0] = 16'h1101;
        ref_mem[1] = 16'h1202;
        ref_mem[2] = 16'h2312;
        ref_mem[3] = 16'h3412;
        ref_mem[4] = 16'h4000;
        ref_mem[5] = 16'hF000;

        reset  = 1'b1;
        enable = 1'b0;
        pc     = 16'h0000;
`ifdef INSTMEM_LOAD_EN
        load_en   = 1'b0;
        load_addr = 16'h0000;
        load_data = 16'h0000;
`endif

        vt[0]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 16'h0000, 16'h1101, 1'b1, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 16'h0001, 16'h1202, 1'b1, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 16'h0002, 16'h2312, 1'b1, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 16'h0003, 16'h3412, 1'b1, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 16'h0004, 16'h4000, 1'b1, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 16'h0005, 16'hF000, 1'b1, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 16'h0007, 16'hF000, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 16'h0100, 16'h0000, 1'b1, 1'b1};
        vt[10] = '{1'b0, 1'b1, 16'h0002, 16'h2312, 1'b1, 1'b0};
        vt[11] = '{1'b0, 1'b0, 16'h0100, 16'h2312, 1'b0, 1'b0};
        vt[12] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1};
        vt[13] = '{1'b0, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b1};
        vt[14] = '{1'b0, 1'b1, 16'h0004, 16'h4000, 1'b1, 1'b0};
        vt[15] = '{1'b1, 1'b1, 16'h0001, 16'h0000, 1'b0, 1'b0};
        vt[16] = '{1'b0, 1'b1, 16'h0101, 16'h0000, 1'b1, 1'b1};

        for (int i = 0; i < 17; i++) begin
            reset  = vt[i].rst;
            enable = vt[i].en;
            pc     = vt[i].pc;
            tick();
            chk($sformatf("vec%0d_instr", i), instruction, vt[i].instr);
            chk($sformatf("vec%0d_valid", i), 16'(valid), 16'(vt[i].v));
            chk($sformatf("vec%0d_err", i), 16'(addr_err), 16'(vt[i].err));
        end

        // pc wiggling between edges must not disturb outputs
        reset  = 1'b0;
        enable = 1'b1;
        pc     = 16'h0000;
        #2;
        pc = 16'h0005;
        #1;
        chk("midcycle_instr", instruction, 16'h0000);
        chk("midcycle_err", 16'(addr_err), 16'h0001);
        tick();
        chk("edge_pc_instr", instruction, 16'hF000);

`ifdef INSTMEM_LOAD_EN
        // Same-edge load and fetch at one address returns the old word
        load_en   = 1'b1;
        load_addr = 16'h0003;
        load_data = 16'hABCD;
        pc        = 16'h0003;
        tick();
        chk("rbw_old", instruction, 16'h3412);
        load_en = 1'b0;
        tick();
        chk("rbw_new", instruction, 16'hABCD);
        reset = 1'b1;
        tick();
        chk("ld_reset_instr", instruction, 16'h0000);
        reset = 1'b0;
        tick();
        chk("ld_keep_after_reset", instruction, 16'hABCD);
        // Out-of-range load is dropped; addr_err untouched
        load_en   = 1'b1;
        load_addr = 16'h0100;
        load_data = 16'h5555;
        enable    = 1'b0;
        tick();
        chk("oor_load_err", 16'(addr_err), 16'h0000);
        load_en = 1'b0;
        enable  = 1'b1;
        pc      = 16'h0000;
        tick();
        chk("oor_load_word0", instruction, 16'h1101);
        // Load while reset is asserted is overridden
        reset     = 1'b1;
        load_en   = 1'b1;
        load_addr = 16'h0001;
        load_data = 16'h7777;
        tick();
        reset   = 1'b0;
        load_en = 1'b0;
        pc      = 16'h0001;
        tick();
        chk("reset_blocks_load", instruction, 16'h1202);
`endif

        // Randomized run against the model
        for (int n = 0; n < 400; n++) begin
            reset  = ($urandom % 20) == 0;
            enable = ($urandom % 4) != 0;
            case ($urandom % 4)
                0:       pc = 16'($urandom);
                1:       pc = 16'($urandom_range(250, 262));
                default: pc = 16'($urandom % 12);
            endcase
`ifdef INSTMEM_LOAD_EN
            load_en   = ($urandom % 3) == 0;
            load_addr = ($urandom % 5 == 0) ? 16'($urandom) : 16'($urandom % 12);
            load_data = 16'($urandom);
`endif
            tick();
            chk_model($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_mem.md
INST_MEM -- requirements
Module: inst_mem

Interface
REQ-001 SHALL have parameter DEPTH, default 256: number of 16-bit instruction words (power of two, 2..65536).
REQ-002 SHALL have parameter NOP_WORD, default 16'h0000: word returned for out-of-range fetches.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1 bit: fetch enable.
REQ-006 SHALL have port pc, input, 16 bits: word address of the instruction to fetch.
REQ-007 SHALL have port instruction, output, 16 bits, registered: fetched instruction word.
REQ-008 SHALL have port valid, output, 1 bit, registered: high for one cycle per completed fetch.
REQ-009 SHALL have port addr_err, output, 1 bit, registered: the last fetch had pc >= DEPTH.
REQ-010 SHALL have, only when INSTMEM_LOAD_EN is defined, ports load_en (input, 1), load_addr (input, 16) and load_data (input, 16).

Function
REQ-011 SHALL hold DEPTH x 16-bit words, initialised at elaboration to the boot image: addr0=16'h1101, addr1=16'h1202, addr2=16'h2312, addr3=16'h3412, addr4=16'h4000, addr5=16'hF000, all other addresses 16'h0000.
REQ-012 SHALL, on a rising edge with reset=0 and enable=1, register instruction<=mem[pc], valid<=1 and addr_err<=0 when pc < DEPTH, giving a latency of one clock from pc to instruction.
REQ-013 SHALL, on an enabled fetch with pc >= DEPTH, register instruction<=NOP_WORD, valid<=1 and addr_err<=1, with no address wrap-around.
REQ-014 SHALL, on a rising edge with reset=0 and enable=0, hold instruction and addr_err unchanged and drive valid<=0.
REQ-015 SHALL make pc changes between clock edges have no effect on outputs, which change only on the rising edge of clk.
REQ-016 SHALL, with INSTMEM_LOAD_EN defined, on a rising edge with reset=0, load_en=1 and load_addr < DEPTH, write load_data into mem[load_addr].
REQ-017 SHALL ignore a load with load_addr >= DEPTH, leaving memory unchanged and addr_err unaffected.
REQ-018 SHALL, on a same-edge load and fetch to the same address, return the old word to the fetch (read-before-write); the new word appears on the next fetch.
REQ-019 SHALL allow load and fetch to proceed independently in the same cycle regardless of enable.

Reset
REQ-020 SHALL, on a rising edge with reset=1, drive instruction<=16'h0000, valid<=0 and addr_err<=0, with reset overriding enable and load_en.
REQ-021 SHALL leave memory contents (boot image or loaded words) unaltered on reset.
REQ-022 SHALL define outputs from the first edge with reset=1; asserting reset mid-fetch discards that fetch.

Configuration
REQ-023 SHALL, with macro INSTMEM_LOAD_EN defined, include the load port and write logic per REQ-016..REQ-019.
REQ-024 SHALL, without INSTMEM_LOAD_EN, omit the load ports and keep the memory read-only, holding the boot image permanently.

Verification
REQ-025 SHALL verify: reset=1 for one edge, then enable=1 with pc=0..5 on successive edges -> instruction 1101, 1202, 2312, 3412, 4000, F000, each one cycle after its pc, with valid=1.
REQ-026 SHALL verify: enable=0 after pc=5 -> instruction holds F000 and valid=0; then reset=1 -> instruction=0000, valid=0.
REQ-027 SHALL verify: DEPTH=256, enable=1, pc=16'h0100 -> instruction=0000, addr_err=1; next fetch at pc=2 -> 2312, addr_err=0.
REQ-028 SHALL verify: reset=1 and enable=1 on the same edge with pc=1 -> instruction=0000, valid=0.
REQ-029 SHALL verify (INSTMEM_LOAD_EN defined): load_addr=3, load_data=ABCD with a fetch at pc=3 on the same edge -> 3412; the next fetch at pc=3 -> ABCD; after reset a fetch at pc=3 still returns ABCD.
